regbank_mp: RTL and testbench

Parametrised successor to the processor's 2-read/1-write register file, sitting in the ID stage of the pipelined MIPS core. Width, depth and address width are configurable. A post-reset hardware init sequencer loads a defined pattern one entry per cycle, and a `ready` flag gates pipeline start. Optional same-cycle write-to-read bypass removes the WB→ID forwarding hazard.

---
 rtl/regbank_mp.sv | 122 ++++++++++++
 tb/tb_regbank_mp.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regbank_mp.sv
// Parametrised 2-read/1-write register file with a post-reset init sequencer and a ready flag.
// Optional same-cycle write-to-read bypass is enabled by defining REGBANK_MP_BYPASS_EN.
module regbank_mp #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int INIT_MODE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [WIDTH-1:0]  read1,
  output logic [WIDTH-1:0]  read2,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [WIDTH-1:0]  writedata,
  input  logic              write,
  output logic              ready
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {INIT, READY} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               ready_n;
  logic               wr_ok;
  logic [WIDTH-1:0]   stored1, stored2;

  // Entry 0 is hardwired to zero, so only entries 1..DEPTH-1 hold state.
  logic [WIDTH-1:0]   mem [1:DEPTH-1];

  function automatic logic [WIDTH-1:0] init_val(input int k);
    if (INIT_MODE == 1) return WIDTH'(k);
    else                return '0;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < CNT_W'(DEPTH));
  endfunction

`ifdef REGBANK_MP_BYPASS_EN
  function automatic logic bypass_hit(input logic              we,
                                      input logic [ADDR_W-1:0] wa,
                                      input logic [ADDR_W-1:0] ra);
    return we && (wa == ra) && (ra != '0) && in_range(ra);
  endfunction
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ready <= ready_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready_n = ready;
    case (state)
      INIT: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DEPTH - 1)) begin
          state_n = READY;
          ready_n = 1'b1;
        end
      end
      READY: begin
        state_n = READY;
      end
      default: begin
        state_n = INIT;
        cnt_n   = '0;
        ready_n = 1'b0;
      end
    endcase
  end

  // External writes only land once init is done; address 0 and out-of-range are dropped.
  assign wr_ok = write && (state == READY) && (writereg != '0) && in_range(writereg);

  // Storage is never reset: the init sequencer rewrites it after every reset.
  always_ff @(posedge clock) begin
    for (int k = 1; k < DEPTH; k++) begin
      if (state == INIT) begin
        if (cnt == CNT_W'(k)) mem[k] <= init_val(k);
      end else if (wr_ok && (writereg == ADDR_W'(k))) begin
        mem[k] <= writedata;
      end
    end
  end

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int k = 1; k < DEPTH; k++) begin
      if (addr1 == ADDR_W'(k)) stored1 = mem[k];
      if (addr2 == ADDR_W'(k)) stored2 = mem[k];
    end
  end

  always_comb begin
    read1 = '0;
    read2 = '0;
    if (state == READY) begin
      read1 = stored1;
      read2 = stored2;
`ifdef REGBANK_MP_BYPASS_EN
      if (bypass_hit(write, writereg, addr1)) read1 = writedata;
      if (bypass_hit(write, writereg, addr2)) read2 = writedata;
`endif
    end
  end

endmodule

// File: tb/tb_regbank_mp.sv
// Scoreboard bench for regbank_mp: a default instance (INIT_MODE 1) and a DEPTH=20, INIT_MODE 0 instance.
module tb_regbank_mp;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, rst_b;
  logic [4:0]  a_addr1, a_addr2, a_writereg, b_addr1, b_addr2, b_writereg;
  logic [31:0] a_read1, a_read2, a_wd, b_read1, b_read2, b_wd;
  logic        a_write, b_write, a_ready, b_ready;

  regbank_mp #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .INIT_MODE(1)) dut_a (
    .clock(clock), .reset(rst_a), .addr1(a_addr1), .addr2(a_addr2),
    .read1(a_read1), .read2(a_read2), .writereg(a_writereg),
    .writedata(a_wd), .write(a_write), .ready(a_ready)
  );

  regbank_mp #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .INIT_MODE(0)) dut_b (
    .clock(clock), .reset(rst_b), .addr1(b_addr1), .addr2(b_addr2),
    .read1(b_read1), .read2(b_read2), .writereg(b_writereg),
    .writedata(b_wd), .write(b_write), .ready(b_ready)
  );

  typedef struct {
    string       name;
    int          kind;   // 0/1/2 = dut_a read1/read2/ready, 3/4/5 = dut_b read1/read2/ready
    logic [31:0] exp;
  } item_t;

  item_t       q[$];
  int          compared   = 0;
  int          mismatched = 0;
  item_t       it;
  logic [31:0] act;

  localparam logic [31:0] BYP9 =
`ifdef REGBANK_MP_BYPASS_EN
    32'h12345678;
`else
    32'd9;
`endif
  localparam logic [31:0] BYP19 =
`ifdef REGBANK_MP_BYPASS_EN
    32'h55;
`else
    32'h0;
`endif

  task automatic push(input string n, input int kind, input logic [31:0] e);
    item_t x;
    x.name = n;
    x.kind = kind;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every expectation queued during a cycle is checked on the falling edge.
  always @(negedge clock) begin
    while (q.size() > 0) begin
      it = q.pop_front();
      case (it.kind)
        0:       act = a_read1;
        1:       act = a_read2;
        2:       act = {31'b0, a_ready};
        3:       act = b_read1;
        4:       act = b_read2;
        default: act = {31'b0, b_ready};
      endcase
      compared++;
      if (act !== it.exp) begin
        mismatched++;
        $display("FAIL %s: got 0x%0h, want 0x%0h", it.name, act, it.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_addr1 = '0; a_addr2 = '0; a_writereg = '0; a_wd = '0; a_write = 1'b0;
    b_addr1 = '0; b_addr2 = '0; b_writereg = '0; b_wd = '0; b_write = 1'b0;

    step();
    push("a_ready_reset", 2, 32'd0);
    push("a_read1_reset", 0, 32'd0);
    step();
    rst_a = 1'b0;
    a_addr1 = 5'd7;
    a_addr2 = 5'd31;
    for (int e = 1; e <= 32; e++) begin
      if (e == 3)  begin a_write = 1'b1; a_writereg = 5'd5; a_wd = 32'hDEADBEEF; end
      if (e == 32) begin a_write = 1'b1; a_writereg = 5'd6; a_wd = 32'h0000CAFE; end
      step();
      a_write = 1'b0;
      push($sformatf("a_ready_edge%0d", e), 2, (e == 32) ? 32'd1 : 32'd0);
      if (e < 32) push($sformatf("a_read1_init_edge%0d", e), 0, 32'd0);
    end
    push("a_read1_addr7", 0, 32'd7);
    push("a_read2_addr31", 1, 32'd31);

    step();
    a_addr1 = 5'd5; a_addr2 = 5'd6;
    push("a_init_write_discarded", 0, 32'd5);
    push("a_ready_edge_write_discarded", 1, 32'd6);

    step();
    a_write = 1'b1; a_writereg = 5'd0; a_wd = 32'hFFFFFFFF;
    a_addr1 = 5'd0; a_addr2 = 5'd0;
    push("a_reg0_same_cycle", 0, 32'd0);
    push("a_reg0_port2_same_cycle", 1, 32'd0);
    step();
    a_write = 1'b0;
    push("a_reg0_next_cycle", 0, 32'd0);

    step();
    a_addr1 = 5'd9; a_addr2 = 5'd10;
    a_write = 1'b1; a_writereg = 5'd9; a_wd = 32'h12345678;
    push("a_rw9_same_cycle", 0, BYP9);
    push("a_read2_addr10_unaffected", 1, 32'd10);
    step();
    a_write = 1'b0;
    push("a_rw9_after_edge", 0, 32'h12345678);

    step();
    a_write = 1'b1; a_writereg = 5'd3; a_wd = 32'hAA; a_addr1 = 5'd3;
    step();
    a_write = 1'b0;
    push("a_write3_readback", 0, 32'hAA);

    step();
    #2;
    rst_a = 1'b1;
    #1;
    push("a_ready_async_drop", 2, 32'd0);
    push("a_read1_in_reset", 0, 32'd0);
    @(negedge clock);
    #1;
    rst_a = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      push($sformatf("a_reinit_ready_edge%0d", e), 2, (e == 32) ? 32'd1 : 32'd0);
    end
    push("a_addr3_reinit", 0, 32'd3);
    push("a_addr10_reinit", 1, 32'd10);

    b_addr1 = 5'd7; b_addr2 = 5'd19;
    rst_b = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      step();
      push($sformatf("b_ready_edge%0d", e), 5, (e == 20) ? 32'd1 : 32'd0);
    end
    push("b_addr7_zero_init", 3, 32'd0);
    push("b_addr19_zero_init", 4, 32'd0);

    step();
    b_write = 1'b1; b_writereg = 5'd25; b_wd = 32'h77;
    b_addr1 = 5'd25; b_addr2 = 5'd20;
    push("b_addr25_same_cycle", 3, 32'd0);
    push("b_addr20_out_of_range", 4, 32'd0);
    step();
    b_write = 1'b1; b_writereg = 5'd19; b_wd = 32'h55;
    b_addr2 = 5'd19;
    push("b_addr25_discarded", 3, 32'd0);
    push("b_addr19_same_cycle", 4, BYP19);
    step();
    b_write = 1'b0;
    push("b_addr19_readback", 4, 32'h55);

    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
